// File: rtl/tx_sched_pkg.sv
// Shared types and defaults for the transmit frame scheduler in front of the senter.
// Frame length tracks the senter's sample memory depth so one frame fills it once.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  localparam int SRC_DATA = 0;
  localparam int SRC_CTRL = 1;

  localparam int SENTER_ADDR_MEM_WIDTH = 5;
  localparam int DEF_FRAME_WORDS       = 1 << SENTER_ADDR_MEM_WIDTH;
  // Two frame lengths of silence gives the receiver time to re-lock on the m-sequence head.
  localparam int DEF_GAP_CYCLES        = 2 * DEF_FRAME_WORDS;

endpackage

// File: rtl/tx_frame_sched_rr_arb2.sv
// Two-requester round-robin arbiter: the one-hot grant is registered on strobe and
// held until clear; the last winner loses the next tie.
module rr_arb2
  import tx_sched_pkg::*;
(
  input  logic       clk,
  input  logic       arst_n,
  input  logic [1:0] req,
  input  logic       strobe,
  input  logic       clear,
  output logic [1:0] grant
);

  logic       last_q;
  logic [1:0] pick;
  logic [1:0] grant_q;

  always_comb begin
    pick = req;
    if (&req) pick = last_q ? 2'b01 : 2'b10;
  end

  // last_q resets to the control port so the data port wins the first tie.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      grant_q <= '0;
      last_q  <= 1'b1;
    end else if (strobe) begin
      grant_q <= pick;
      if (|pick) last_q <= pick[SRC_CTRL];
    end else if (clear) begin
      grant_q <= '0;
    end
  end

  assign grant = grant_q;

endmodule

// File: rtl/tx_frame_sched.sv
// Shares the senter transmit path between a data and a control AXI-stream source,
// cutting grants into tlast-terminated frames followed by a silent gap.
module tx_frame_sched
  import tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    enable,
  input  logic [DATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axis_tkeep,
  input  logic                    s0_axis_tvalid,
  input  logic                    s0_axis_tlast,
  output logic                    s0_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axis_tkeep,
  input  logic                    s1_axis_tvalid,
  input  logic                    s1_axis_tlast,
  output logic                    s1_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [1:0]              grant,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    frame_cnt
);

  localparam int NUM_SRC = 2;
  localparam int KEEP_W  = DATA_WIDTH / 8;
  localparam int WCNT_W  = $clog2(FRAME_WORDS);
  localparam int GCNT_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] s_tdata;
  logic [NUM_SRC-1:0][KEEP_W-1:0]     s_tkeep;
  logic [NUM_SRC-1:0]                 s_tvalid;
  logic [NUM_SRC-1:0]                 s_tlast;
  logic [NUM_SRC-1:0]                 s_tready;

  assign s_tdata  = {s1_axis_tdata,  s0_axis_tdata};
  assign s_tkeep  = {s1_axis_tkeep,  s0_axis_tkeep};
  assign s_tvalid = {s1_axis_tvalid, s0_axis_tvalid};
  assign s_tlast  = {s1_axis_tlast,  s0_axis_tlast};
  assign s0_axis_tready = s_tready[SRC_DATA];
  assign s1_axis_tready = s_tready[SRC_CTRL];

  sched_state_t         state_q, state_d;
  logic [WCNT_W-1:0]    word_cnt_q;
  logic [GCNT_W-1:0]    gap_cnt_q;
  logic [CNT_WIDTH-1:0] frame_cnt_q;
  logic [NUM_SRC-1:0]   grant_q;
  logic                 sel;
  logic                 in_send;
  logic                 hs;
  logic                 word_last;
  logic                 frame_end;
  logic                 gap_done;
  logic                 arb_strobe;

  rr_arb2 u_arb (
    .clk    (clk),
    .arst_n (arst_n),
    .req    (s_tvalid),
    .strobe (arb_strobe),
    .clear  (frame_end),
    .grant  (grant_q)
  );

  // grant_q is one-hot and only non-zero in SEND, so its upper bit picks the source.
  assign sel     = grant_q[SRC_CTRL];
  assign in_send = (state_q == SEND);

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    s_tready      = '0;
    if (in_send) begin
      m_axis_tvalid = s_tvalid[sel];
      m_axis_tdata  = s_tdata[sel];
      m_axis_tkeep  = s_tkeep[sel];
      s_tready      = grant_q & {NUM_SRC{m_axis_tready}};
    end
  end

  assign word_last    = (word_cnt_q == WCNT_W'(FRAME_WORDS - 1));
  assign m_axis_tlast = m_axis_tvalid & (word_last | s_tlast[sel]);
  assign hs           = m_axis_tvalid & m_axis_tready;
  assign frame_end    = hs & m_axis_tlast;
  assign gap_done     = (gap_cnt_q == GCNT_W'(GAP_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    arb_strobe = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (|s_tvalid)) begin
          arb_strobe = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (frame_end) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (frame_end)  word_cnt_q <= '0;
      else if (hs)    word_cnt_q <= word_cnt_q + WCNT_W'(1);
      if (state_q == GAP) gap_cnt_q <= gap_done ? '0 : gap_cnt_q + GCNT_W'(1);
      if (frame_end)  frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Scoreboard bench for tx_frame_sched: per-source expected words are queued when
// stimulus is loaded and popped as the scheduler emits them.
module tb_tx_frame_sched;

  localparam int DW  = 32;
  localparam int KW  = DW / 8;
  localparam int FW  = 32;
  localparam int GAP = 64;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] s0_tdata = '0, s1_tdata = '0;
  logic [KW-1:0] s0_tkeep = '0, s1_tkeep = '0;
  logic          s0_tvalid = 1'b0, s0_tlast = 1'b0, s1_tvalid = 1'b0, s1_tlast = 1'b0;
  logic          s0_tready, s1_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b0;
  logic [1:0]    grant;
  logic          busy;
  logic [CW-1:0] frame_cnt;

  tx_frame_sched #(.DATA_WIDTH(DW), .FRAME_WORDS(FW), .GAP_CYCLES(GAP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tvalid(s0_tvalid),
    .s0_axis_tlast(s0_tlast), .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tvalid(s1_tvalid),
    .s1_axis_tlast(s1_tlast), .s1_axis_tready(s1_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .grant(grant), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, words_out = 0, exp_frames = 0, gap_run = 0;
  bit rnd_valid = 0, rnd_ready = 0, in_frame = 0;
  logic [DW:0] srcq0[$], srcq1[$], expq0[$], expq1[$];
  logic [1:0]  gexp[$];
  int          gap_runs[$], start_cyc[$];

  function automatic logic [KW-1:0] keep_of(input logic [DW-1:0] d);
    return d[KW-1:0] ^ 4'hA;
  endfunction

  // Source words carry their own tlast; expected words also mark the FW-word cut.
  task automatic load_src(input int port, input logic [DW-1:0] base, input int n, input int tlast_at);
    int k;
    logic lst;
    logic [DW:0] e;
    k = 0;
    for (int i = 0; i < n; i++) begin
      e   = {(i == tlast_at), base + DW'(i)};
      lst = (k == FW - 1) || (i == tlast_at);
      k   = lst ? 0 : k + 1;
      if (port == 0) begin srcq0.push_back(e); expq0.push_back({lst, e[DW-1:0]}); end
      else           begin srcq1.push_back(e); expq1.push_back({lst, e[DW-1:0]}); end
    end
  endtask

  task automatic clear_stats();
    words_out = 0; gap_run = 0; in_frame = 0;
    gap_runs.delete(); start_cyc.delete(); gexp.delete();
  endtask

  task automatic drive_inputs();
    if (srcq0.size() > 0 && (!rnd_valid || $urandom_range(0, 3) != 0)) begin
      s0_tvalid = 1'b1; s0_tdata = srcq0[0][DW-1:0]; s0_tlast = srcq0[0][DW];
    end else begin
      s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0;
    end
    if (srcq1.size() > 0 && (!rnd_valid || $urandom_range(0, 3) != 0)) begin
      s1_tvalid = 1'b1; s1_tdata = srcq1[0][DW-1:0]; s1_tlast = srcq1[0][DW];
    end else begin
      s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0;
    end
    s0_tkeep = keep_of(s0_tdata);
    s1_tkeep = keep_of(s1_tdata);
    m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic observe();
    logic [DW:0] e;
    logic [1:0]  g;
    bit have;
    cyc++;
    n_checks++;
    if ((s0_tready && grant !== 2'b01) || (s1_tready && grant !== 2'b10)) begin
      n_fail++;
      $display("FAIL tready_route: s0_tready=%b s1_tready=%b with grant=%b", s0_tready, s1_tready, grant);
    end
    if (busy && grant == 2'b00) gap_run++;
    else if (gap_run > 0) begin gap_runs.push_back(gap_run); gap_run = 0; end
    if (m_tvalid && m_tready) begin
      have = 1'b1;
      e = '0;
      if (grant == 2'b01 && expq0.size() > 0)      e = expq0.pop_front();
      else if (grant == 2'b10 && expq1.size() > 0) e = expq1.pop_front();
      else begin
        have = 1'b0;
        n_checks++; n_fail++;
        $display("FAIL unexpected_word: got %h on grant %b, expected no word", m_tdata, grant);
      end
      if (have) begin
        words_out++;
        if (!in_frame) begin
          start_cyc.push_back(cyc);
          in_frame = 1'b1;
          if (gexp.size() > 0) begin
            g = gexp.pop_front();
            n_checks++;
            if (grant !== g) begin n_fail++; $display("FAIL grant_order: got %b expected %b", grant, g); end
          end
        end
        n_checks++;
        if (m_tdata !== e[DW-1:0]) begin n_fail++; $display("FAIL tdata: got %h expected %h", m_tdata, e[DW-1:0]); end
        n_checks++;
        if (m_tkeep !== keep_of(e[DW-1:0])) begin n_fail++; $display("FAIL tkeep: got %h expected %h", m_tkeep, keep_of(e[DW-1:0])); end
        n_checks++;
        if (m_tlast !== e[DW]) begin n_fail++; $display("FAIL tlast: got %b expected %b for word %h", m_tlast, e[DW], e[DW-1:0]); end
        if (e[DW]) begin in_frame = 1'b0; exp_frames++; end
      end
    end
    if (s0_tvalid && s0_tready && srcq0.size() > 0) void'(srcq0.pop_front());
    if (s1_tvalid && s1_tready && srcq1.size() > 0) void'(srcq1.pop_front());
  endtask

  task automatic cycle();
    @(negedge clk);
    drive_inputs();
    #1;
    observe();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    bit pending;
    n = 0;
    do begin
      cycle();
      n++;
      pending = (srcq0.size() + srcq1.size() + expq0.size() + expq1.size() > 0) || busy;
    end while (pending && n < budget);
    n_checks++;
    if (pending) begin n_fail++; $display("FAIL %s_timeout: still pending after %0d cycles, expected drained", name, n); end
  endtask

  task automatic check_frame_cnt(input string name);
    n_checks++;
    if (frame_cnt !== CW'(exp_frames)) begin
      n_fail++; $display("FAIL %s_frame_cnt: got %0d expected %0d", name, frame_cnt, exp_frames);
    end
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    srcq0.delete(); srcq1.delete(); expq0.delete(); expq1.delete();
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tlast = 1'b0; s1_tlast = 1'b0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    exp_frames = 0;
    clear_stats();
  endtask

  task automatic test_reset();
    enable = 1'b1; s0_tvalid = 1'b1; s1_tvalid = 1'b1; s0_tdata = 32'hDEAD_BEEF; s0_tkeep = 4'hF;
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks += 9;
    if (grant !== 2'b00)    begin n_fail++; $display("FAIL rst_grant: got %b expected 00", grant); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (frame_cnt !== '0)   begin n_fail++; $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt); end
    if (m_tvalid !== 1'b0)  begin n_fail++; $display("FAIL rst_tvalid: got %b expected 0", m_tvalid); end
    if (m_tlast !== 1'b0)   begin n_fail++; $display("FAIL rst_tlast: got %b expected 0", m_tlast); end
    if (m_tdata !== '0)     begin n_fail++; $display("FAIL rst_tdata: got %h expected 0", m_tdata); end
    if (m_tkeep !== '0)     begin n_fail++; $display("FAIL rst_tkeep: got %h expected 0", m_tkeep); end
    if (s0_tready !== 1'b0) begin n_fail++; $display("FAIL rst_s0_tready: got %b expected 0", s0_tready); end
    if (s1_tready !== 1'b0) begin n_fail++; $display("FAIL rst_s1_tready: got %b expected 0", s1_tready); end
    @(negedge clk);
    arst_n = 1'b1; s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tdata = '0; s0_tkeep = '0;
    @(negedge clk); #1;
    n_checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_req: grant=%b busy=%b expected 00/0", grant, busy);
    end
  endtask

  task automatic test_single_port();
    clear_stats();
    enable = 1'b1;
    load_src(0, 32'h1234_5670, 70, 69);
    drain("single", 1000);
    n_checks++;
    if (words_out != 70) begin n_fail++; $display("FAIL single_words: got %0d expected 70", words_out); end
    check_frame_cnt("single");
    n_checks++;
    if (exp_frames != 3) begin n_fail++; $display("FAIL single_frames: got %0d expected 3", exp_frames); end
    n_checks++;
    if (gap_runs.size() != 3) begin n_fail++; $display("FAIL single_gap_count: got %0d expected 3", gap_runs.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (gap_runs[i] != GAP) begin n_fail++; $display("FAIL single_gap_len: gap %0d got %0d expected %0d", i, gap_runs[i], GAP); end
    end
    n_checks++;
    if (start_cyc.size() != 3) begin n_fail++; $display("FAIL single_starts: got %0d expected 3", start_cyc.size()); end
    else for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (start_cyc[i+1] - start_cyc[i] != FW + GAP + 1) begin
        n_fail++; $display("FAIL single_period: got %0d expected %0d", start_cyc[i+1] - start_cyc[i], FW + GAP + 1);
      end
    end
  endtask

  task automatic test_alternate();
    do_reset();
    enable = 1'b1;
    load_src(0, 32'hA000_0000, 40, 39);
    load_src(1, 32'hC000_0000, 40, 39);
    gexp.push_back(2'b01); gexp.push_back(2'b10); gexp.push_back(2'b01); gexp.push_back(2'b10);
    drain("alternate", 2000);
    n_checks++;
    if (gexp.size() != 0) begin n_fail++; $display("FAIL alt_grants_left: got %0d expected 0", gexp.size()); end
    check_frame_cnt("alternate");
  endtask

  task automatic test_short_frame();
    int n;
    clear_stats();
    enable = 1'b1;
    load_src(1, 32'hB000_0000, 5, 4);
    gexp.push_back(2'b10);
    n = 0;
    while (grant !== 2'b10 && n < 10) begin cycle(); n++; end
    n_checks++;
    if (grant !== 2'b10) begin n_fail++; $display("FAIL short_grant: got %b expected 10", grant); end
    load_src(0, 32'hD000_0000, 3, 2);
    gexp.push_back(2'b01);
    drain("short", 500);
    n_checks++;
    if (gap_runs.size() < 1 || gap_runs[0] != GAP) begin
      n_fail++; $display("FAIL short_gap: got %0d runs (first %0d) expected %0d", gap_runs.size(),
                         gap_runs.size() > 0 ? gap_runs[0] : -1, GAP);
    end
    check_frame_cnt("short");
  endtask

  task automatic test_random_ready();
    clear_stats();
    enable = 1'b1; rnd_valid = 1'b1; rnd_ready = 1'b1;
    load_src(0, 32'h6000_0000, 40, 39);
    load_src(1, 32'h6100_0000, 40, 39);
    drain("random", 4000);
    rnd_valid = 1'b0; rnd_ready = 1'b0;
    n_checks++;
    if (words_out != 80) begin n_fail++; $display("FAIL random_words: got %0d expected 80", words_out); end
    check_frame_cnt("random");
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    enable = 1'b1;
    load_src(0, 32'h5000_0000, 20, 19);
    n = 0;
    while (words_out < 9 && n < 200) begin cycle(); n++; end
    @(negedge clk);
    drive_inputs();
    #1;
    n_checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h5000_0009) begin
      n_fail++; $display("FAIL mid_word10: got valid=%b data=%h expected 1/50000009", m_tvalid, m_tdata);
    end
    #1 arst_n = 1'b0;
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tkeep !== '0 || m_tlast !== 1'b0 ||
        s0_tready !== 1'b0 || s1_tready !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async_reset: got valid=%b data=%h keep=%h last=%b rdy=%b%b grant=%b busy=%b expected all 0",
               m_tvalid, m_tdata, m_tkeep, m_tlast, s1_tready, s0_tready, grant, busy);
    end
    do_reset();
    load_src(0, 32'h5100_0000, 40, 39);
    load_src(1, 32'h5200_0000, 4, 3);
    gexp.push_back(2'b01); gexp.push_back(2'b10);
    drain("reset_mid", 1000);
    check_frame_cnt("reset_mid");
  endtask

  task automatic test_enable_drop();
    int n, bad;
    clear_stats();
    enable = 1'b1;
    load_src(0, 32'h7000_0000, 50, 49);
    n = 0;
    while (words_out < 5 && n < 50) begin cycle(); n++; end
    enable = 1'b0;
    n = 0;
    do begin cycle(); n++; end while (busy && n < 300);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL en_drop_idle: busy=%b expected 0", busy); end
    n_checks++;
    if (expq0.size() != 18) begin n_fail++; $display("FAIL en_drop_remaining: got %0d expected 18", expq0.size()); end
    check_frame_cnt("en_drop");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (busy || grant != 2'b00 || m_tvalid) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL en_drop_hold: got %0d active cycles expected 0", bad); end
    enable = 1'b1;
    drain("en_resume", 500);
    check_frame_cnt("en_resume");
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_alternate();
    test_short_frame();
    test_random_ready();
    test_reset_mid();
    test_enable_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
